// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : Shared constants for the coprocessor-0 controller: register
//               addresses, Status/Cause field positions and the interrupt
//               exception code, plus the EPC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

    // Register select values seen on CP0Addr
    localparam logic [4:0] c_addr_count   = 5'd9;
    localparam logic [4:0] c_addr_compare = 5'd11;
    localparam logic [4:0] c_addr_sr      = 5'd12;
    localparam logic [4:0] c_addr_cause   = 5'd13;
    localparam logic [4:0] c_addr_epc     = 5'd14;
    localparam logic [4:0] c_addr_prid    = 5'd15;

    // Field positions inside Status and Cause
    localparam int c_bit_ie      = 0;
    localparam int c_bit_exl     = 1;
    localparam int c_ip_base     = 8;
    localparam int c_exccode_lsb = 2;
    localparam int c_bit_ti      = 30;
    localparam int c_bit_bd      = 31;

    // ExcCode recorded when an interrupt is taken
    localparam logic [4:0] c_exc_int = 5'd0;

    // Restart address: a delay-slot instruction restarts at its branch
    function automatic logic [31:0] epc_align(input logic [31:0] vpc, input logic bd);
        logic [31:0] t;
        t = bd ? (vpc - 32'd4) : vpc;
        return {t[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp0_timer.sv
// ============================================================================
// Module      : cp0_timer
// Description : Free-running Count register, Compare register and the sticky
//               timer interrupt flag TI raised on a Count/Compare match.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] CP0In,
    output logic [31:0] Count,
    output logic [31:0] Compare,
    output logic        TI
);

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;

    // Count/Compare registers; a Compare write clears TI ahead of any match
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 32'h0000_0000;
            r_compare <= 32'hFFFF_FFFF;
            r_ti      <= 1'b0;
        end else begin
            if (count_we) r_count <= CP0In;
            else          r_count <= r_count + 32'd1;

            if (compare_we) begin
                r_compare <= CP0In;
                r_ti      <= 1'b0;
            end else if (r_count == r_compare) begin
                r_ti      <= 1'b1;
            end
        end
    end

    assign Count   = r_count;
    assign Compare = r_compare;
    assign TI      = r_ti;

endmodule

`default_nettype wire

// File: rtl/cp0_ctrl.sv
// ============================================================================
// Module      : cp0_ctrl
// Description : M-stage coprocessor-0 controller. Decides exception and
//               interrupt entry, maintains SR/Cause/EPC and returns EPC for
//               eret. Optional Count/Compare timer enabled by the
//               CP0_TIMER_EN macro; the timer takes interrupt line HW_INT_W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter int          HW_INT_W = 6,
    parameter logic [31:0] PRID     = 32'h0000_0001
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                WE,
    input  logic [4:0]          CP0Addr,
    input  logic [31:0]         CP0In,
    output logic [31:0]         CP0Out,
    input  logic [31:0]         VPC,
    input  logic                BDIn,
    input  logic [4:0]          ExcCodeIn,
    input  logic [HW_INT_W-1:0] HWInt,
    input  logic                EXLClr,
    output logic [31:0]         EPCOut,
    output logic                Req
);

`ifdef CP0_TIMER_EN
    localparam int NINT = HW_INT_W + 1;
`else
    localparam int NINT = HW_INT_W;
`endif

    logic [31:0]     r_sr;
    logic [31:0]     r_epc;
    logic [4:0]      r_exccode;
    logic [NINT-1:0] r_ip;
    logic            r_bd;

    logic [NINT-1:0] w_ip_now;
    logic            w_ti;
    logic            w_int_req;
    logic            w_exc_req;
    logic            w_wr;
    logic [31:0]     w_cause;

`ifdef CP0_TIMER_EN
    logic [31:0] w_count;
    logic [31:0] w_compare;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (w_wr && (CP0Addr == c_addr_count)),
        .compare_we (w_wr && (CP0Addr == c_addr_compare)),
        .CP0In      (CP0In),
        .Count      (w_count),
        .Compare    (w_compare),
        .TI         (w_ti)
    );

    assign w_ip_now = {w_ti, HWInt};
`else
    assign w_ti     = 1'b0;
    assign w_ip_now = HWInt;
`endif

    // Pending lines are used unregistered so an interrupt is seen the same cycle
    assign w_int_req = (|(w_ip_now & r_sr[c_ip_base +: NINT])) && !r_sr[c_bit_exl] && r_sr[c_bit_ie];
    assign w_exc_req = (ExcCodeIn != 5'd0) && !r_sr[c_bit_exl];
    assign Req       = w_int_req || w_exc_req;
    assign w_wr      = WE && !Req;
    assign EPCOut    = r_epc;

    // Assemble the Cause view from hardware-owned fields
    always_comb begin
        w_cause                              = 32'h0000_0000;
        w_cause[c_bit_bd]                    = r_bd;
        w_cause[c_bit_ti]                    = w_ti;
        w_cause[c_ip_base +: NINT]           = r_ip;
        w_cause[c_exccode_lsb +: 5]          = r_exccode;
    end

    // mfc0 read mux; unmapped addresses read zero
    always_comb begin
        CP0Out = 32'h0000_0000;
        case (CP0Addr)
`ifdef CP0_TIMER_EN
            c_addr_count:   CP0Out = w_count;
            c_addr_compare: CP0Out = w_compare;
`endif
            c_addr_sr:      CP0Out = r_sr;
            c_addr_cause:   CP0Out = w_cause;
            c_addr_epc:     CP0Out = r_epc;
            c_addr_prid:    CP0Out = PRID;
            default:        CP0Out = 32'h0000_0000;
        endcase
    end

    // Entry bookkeeping, eret and mtc0 updates; entry takes priority over both
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr      <= 32'h0000_0000;
            r_epc     <= 32'h0000_0000;
            r_exccode <= 5'd0;
            r_ip      <= '0;
            r_bd      <= 1'b0;
        end else begin
            r_ip <= w_ip_now;
            if (Req) begin
                r_sr[c_bit_exl] <= 1'b1;
                r_bd            <= BDIn;
                r_exccode       <= w_int_req ? c_exc_int : ExcCodeIn;
                r_epc           <= epc_align(VPC, BDIn);
            end else begin
                if (w_wr && (CP0Addr == c_addr_sr))  r_sr  <= CP0In;
                if (EXLClr)                          r_sr[c_bit_exl] <= 1'b0;
                if (w_wr && (CP0Addr == c_addr_epc)) r_epc <= {CP0In[31:2], 2'b00};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cp0_ctrl.sv
// ============================================================================
// Module      : tb_cp0_ctrl
// Description : Self-checking bench for cp0_ctrl. A table of per-cycle
//               vectors covers entry, eret, priority and register access;
//               hand sequences cover the timer (when CP0_TIMER_EN is
//               defined) and reset in the middle of a handler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cp0_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic [31:0] vpc = 32'd0;
    logic        bd = 1'b0;
    logic [4:0]  exc = 5'd0;
    logic [5:0]  hw = 6'd0;
    logic        clr = 1'b0;
    logic [31:0] epc;
    logic        req;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cp0_ctrl #(.HW_INT_W(6), .PRID(32'h0000_0001)) dut (
        .clk       (clk),
        .reset     (reset),
        .WE        (we),
        .CP0Addr   (addr),
        .CP0In     (din),
        .CP0Out    (dout),
        .VPC       (vpc),
        .BDIn      (bd),
        .ExcCodeIn (exc),
        .HWInt     (hw),
        .EXLClr    (clr),
        .EPCOut    (epc),
        .Req       (req)
    );

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] vpc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        req;
        logic [31:0] out;
        logic [31:0] epc;
    } vec_t;

    vec_t tv[28];

    function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] v, input logic b, input logic [4:0] e,
                                input logic [5:0] h, input logic c, input logic r,
                                input logic [31:0] o, input logic [31:0] p);
        vec_t t;
        t.we = w; t.addr = a; t.din = d; t.vpc = v; t.bd = b; t.exc = e;
        t.hw = h; t.clr = c; t.req = r; t.out = o; t.epc = p;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs just after the falling edge, settle, return
    task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d = 32'd0,
                       input logic [31:0] v = 32'd0, input logic b = 1'b0,
                       input logic [4:0] e = 5'd0, input logic [5:0] h = 6'd0,
                       input logic c = 1'b0);
        @(negedge clk);
        we = w; addr = a; din = d; vpc = v; bd = b; exc = e; hw = h; clr = c;
        #1;
    endtask

    initial begin
        //          we addr din           vpc          bd exc    hw   clr req out           epc
        tv[0]  = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h0);
        tv[1]  = mk(0, 13, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h0);
        tv[2]  = mk(0, 14, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h0);
        tv[3]  = mk(0, 15, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h1,        32'h0);
        tv[4]  = mk(0, 3,  32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h0);
        tv[5]  = mk(1, 12, 32'h101,      32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h0);
        tv[6]  = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h101,      32'h0);
        tv[7]  = mk(0, 13, 32'h0,        32'h3000,    0, 5'd0,  6'd1, 0, 1, 32'h0,        32'h0);
        tv[8]  = mk(0, 13, 32'h0,        32'h0,       0, 5'd0,  6'd1, 0, 0, 32'h100,      32'h3000);
        tv[9]  = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h103,      32'h3000);
        tv[10] = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd1, 1, 0, 32'h103,      32'h3000);
        tv[11] = mk(0, 12, 32'h0,        32'h3010,    0, 5'd0,  6'd1, 0, 1, 32'h101,      32'h3000);
        tv[12] = mk(0, 14, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h3010,     32'h3010);
        tv[13] = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 1, 0, 32'h103,      32'h3010);
        tv[14] = mk(0, 12, 32'h0,        32'h3008,    1, 5'd12, 6'd0, 0, 1, 32'h101,      32'h3010);
        tv[15] = mk(0, 13, 32'h0,        32'h4000,    0, 5'd12, 6'd0, 0, 0, 32'h8000_0030, 32'h3004);
        tv[16] = mk(0, 14, 32'h0,        32'h0,       0, 5'd0,  6'd0, 1, 0, 32'h3004,     32'h3004);
        tv[17] = mk(1, 12, 32'h0,        32'h5001,    0, 5'd10, 6'd1, 0, 1, 32'h101,      32'h3004);
        tv[18] = mk(0, 13, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h100,      32'h5000);
        tv[19] = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h103,      32'h5000);
        tv[20] = mk(1, 14, 32'h1237,     32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h5000,     32'h5000);
        tv[21] = mk(1, 13, 32'hFFFF_FFFF, 32'h0,      0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h1234);
        tv[22] = mk(1, 15, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h1,        32'h1234);
        tv[23] = mk(0, 13, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h0,        32'h1234);
        tv[24] = mk(0, 15, 32'h0,        32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h1,        32'h1234);
        tv[25] = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd0, 1, 0, 32'h103,      32'h1234);
        tv[26] = mk(1, 12, 32'h100,      32'h0,       0, 5'd0,  6'd0, 0, 0, 32'h101,      32'h1234);
        tv[27] = mk(0, 12, 32'h0,        32'h0,       0, 5'd0,  6'd1, 0, 0, 32'h100,      32'h1234);

        // Synchronous reset for two edges
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 28; i++) begin
            cyc(tv[i].we, tv[i].addr, tv[i].din, tv[i].vpc, tv[i].bd, tv[i].exc, tv[i].hw, tv[i].clr);
            chk($sformatf("vec%0d req", i), {31'd0, req}, {31'd0, tv[i].req});
            chk($sformatf("vec%0d cp0out", i), dout, tv[i].out);
            chk($sformatf("vec%0d epcout", i), epc, tv[i].epc);
        end

`ifdef CP0_TIMER_EN
        // Timer: IM[6] (TI) and IE enabled, Compare=5, Count=0
        cyc(1, 12, 32'h4001);
        cyc(1, 11, 32'd5);
        cyc(1, 9, 32'd0);
        cyc(0, 9);
        chk("count after load", dout, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            cyc(0, 13, 32'd0, 32'h6000);
            chk($sformatf("timer wait%0d req", k), {31'd0, req}, 32'd0);
            chk($sformatf("timer wait%0d ti", k), dout & 32'h4000_0000, 32'd0);
        end
        cyc(0, 13, 32'd0, 32'h6000);
        chk("timer fire req", {31'd0, req}, 32'd1);
        chk("timer fire cause", dout, 32'h4000_0000);
        cyc(1, 11, 32'd6);
        chk("timer epc", epc, 32'h6000);
        chk("timer req in handler", {31'd0, req}, 32'd0);
        cyc(0, 13);
        chk("ti cleared by compare write", dout & 32'h4000_0000, 32'd0);
        cyc(0, 11);
        chk("compare readback", dout, 32'd6);
        // Count wrap
        cyc(1, 9, 32'hFFFF_FFFF);
        cyc(0, 9);
        chk("count max", dout, 32'hFFFF_FFFF);
        cyc(0, 9);
        chk("count wrap", dout, 32'd0);
`else
        // Without the timer, 9/11 read zero and ignore writes
        cyc(1, 9, 32'h55);
        cyc(1, 11, 32'h66);
        cyc(0, 9);
        chk("count absent", dout, 32'd0);
        cyc(0, 11);
        chk("compare absent", dout, 32'd0);
        cyc(0, 12, 32'd0, 32'h7000, 1'b0, 5'd4);
        chk("exception entry req", {31'd0, req}, 32'd1);
`endif
        cyc(0, 12);
        chk("in handler exl", dout & 32'h2, 32'h2);

        // Reset in the middle of a handler
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 12);
        chk("post-reset sr", dout, 32'd0);
        chk("post-reset req", {31'd0, req}, 32'd0);
        cyc(0, 13);
        chk("post-reset cause", dout, 32'd0);
        cyc(0, 14);
        chk("post-reset epc", dout, 32'd0);
        chk("post-reset epcout", epc, 32'd0);
        cyc(0, 11);
`ifdef CP0_TIMER_EN
        chk("post-reset compare", dout, 32'hFFFF_FFFF);
`else
        chk("post-reset compare", dout, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
